// File: rtl/sc_stream_counter_pkg.sv
// Shared types and helpers for the stochastic stream counter.
// Bipolar result encoding is selected by STOCH_BIPOLAR_EN.
package sc_stream_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int res_width(input int win_log2);
    return win_log2 + 2;
  endfunction

  // 2*count - 2^win_log2, two's complement in 18 bits
  function automatic logic [17:0] bipolar_offset(
    input logic [17:0] count,
    input int          win_log2
  );
    return (count << 1) - (18'd1 << win_log2);
  endfunction

endpackage

// File: rtl/sc_stream_counter_window_timer.sv
// Enabled sample counter; flags the last sample of a 2^WIN_LOG2 window.
// Wraps to zero naturally after the last sample.
module sc_window_timer
#(
  parameter int WIN_LOG2 = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic sample,
  output logic last
);

  logic [WIN_LOG2-1:0] cnt;

  assign last = sample && (cnt == '1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (sample) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sc_stream_counter.sv
// Stochastic-to-binary converter: counts ones over a fixed window.
// Define STOCH_BIPOLAR_EN for a bipolar (2*count - WIN) result.
module sc_stream_counter
  import sc_stream_counter_pkg::*;
#(
  parameter int WIN_LOG2 = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                START,
  input  logic                IN,
  output logic                BUSY,
  output logic                VALID,
  output logic [WIN_LOG2+1:0] RESULT
);

  localparam int AW = WIN_LOG2 + 1;
  localparam int RW = res_width(WIN_LOG2);

  state_t         state;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  acc_nxt;
  logic [RW-1:0]  result_d;
  logic           sample;
  logic           last;

  assign sample  = (state == RUN) && EN;
  assign acc_nxt = acc + AW'(IN);

`ifdef STOCH_BIPOLAR_EN
  logic [17:0] bip;
  assign bip      = bipolar_offset(18'(acc_nxt), WIN_LOG2);
  assign result_d = bip[RW-1:0];
`else
  assign result_d = {1'b0, acc_nxt};
`endif

  sc_window_timer #(
    .WIN_LOG2(WIN_LOG2)
  ) u_timer (
    .clk   (CLK),
    .rst   (RST),
    .clear (START),
    .sample(sample),
    .last  (last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      acc    <= '0;
      BUSY   <= 1'b0;
      VALID  <= 1'b0;
      RESULT <= '0;
    end else begin
      VALID <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            state <= RUN;
            acc   <= '0;
            BUSY  <= 1'b1;
          end
        end
        RUN: begin
          if (last) begin
            // completion beats a coincident restart
            RESULT <= result_d;
            VALID  <= 1'b1;
            acc    <= '0;
            state  <= START ? RUN : IDLE;
            BUSY   <= START;
          end else if (START) begin
            acc <= '0;
          end else if (EN) begin
            acc <= acc_nxt;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_stream_counter.sv
// Bench for sc_stream_counter: WIN_LOG2=4 and WIN_LOG2=8 instances
// driven in parallel, checked against a window-level reference model.
module tb_sc_stream_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic start = 1'b0;
  logic in_bit = 1'b0;

  logic       busy4, valid4;
  logic [5:0] res4;
  logic       busy8, valid8;
  logic [9:0] res8;

  int checks = 0;
  int passes = 0;
  int fails = 0;

  int wl[2] = '{4, 8};
  bit m_busy[2];
  bit m_valid[2];
  int m_ones[2];
  int m_n[2];
  int m_res[2];

  always #5 clk = ~clk;

  sc_stream_counter #(.WIN_LOG2(4)) dut4 (
    .CLK(clk), .RST(rst), .EN(en), .START(start), .IN(in_bit),
    .BUSY(busy4), .VALID(valid4), .RESULT(res4)
  );

  sc_stream_counter #(.WIN_LOG2(8)) dut8 (
    .CLK(clk), .RST(rst), .EN(en), .START(start), .IN(in_bit),
    .BUSY(busy8), .VALID(valid8), .RESULT(res8)
  );

  function automatic int exp_res(int k, int cnt);
    int v;
`ifdef STOCH_BIPOLAR_EN
    v = 2 * cnt - (1 << wl[k]);
`else
    v = cnt;
`endif
    return v & ((1 << (wl[k] + 2)) - 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h",
             tag, $time, obs, exp);
    end
  endtask

  // Window-level model: a window is WIN enabled samples after START.
  task automatic model_step(bit r, bit s, bit e, bit i);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_busy[k] = 0; m_valid[k] = 0;
        m_ones[k] = 0; m_n[k] = 0; m_res[k] = 0;
      end else begin
        m_valid[k] = 0;
        if (m_busy[k] && e && m_n[k] + 1 == (1 << wl[k])) begin
          m_res[k] = exp_res(k, m_ones[k] + int'(i));
          m_valid[k] = 1;
          m_busy[k] = s;
          m_ones[k] = 0; m_n[k] = 0;
        end else if (s) begin
          m_busy[k] = 1;
          m_ones[k] = 0; m_n[k] = 0;
        end else if (m_busy[k] && e) begin
          m_ones[k] += int'(i);
          m_n[k]++;
        end
      end
    end
  endtask

  task automatic cyc(bit r, bit s, bit e, bit i);
    rst = r; start = s; en = e; in_bit = i;
    @(posedge clk);
    #1;
    model_step(r, s, e, i);
    chk("busy4", 32'(busy4), 32'(m_busy[0]));
    chk("valid4", 32'(valid4), 32'(m_valid[0]));
    chk("result4", 32'(res4), 32'(m_res[0]));
    chk("busy8", 32'(busy8), 32'(m_busy[1]));
    chk("valid8", 32'(valid8), 32'(m_valid[1]));
    chk("result8", 32'(res8), 32'(m_res[1]));
  endtask

  initial begin
    bit tog;
    bit e;
    bit s;

    // reset dominates START/IN
    for (int c = 0; c < 3; c++) cyc(1, 1, 1, 1);
    cyc(0, 0, 0, 0);

    // all-ones window
    cyc(0, 1, 1, 1);
    for (int c = 0; c < 16; c++) cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);

    // alternating stream with five stall cycles
    cyc(0, 1, 0, 0);
    tog = 1;
    for (int c = 0; c < 21; c++) begin
      e = !(c inside {2, 5, 9, 13, 17});
      cyc(0, 0, e, e ? tog : 1'b1);
      if (e) tog = !tog;
    end
    cyc(0, 0, 1, 0);

    // restart mid-window
    cyc(0, 1, 1, 1);
    for (int c = 0; c < 6; c++) cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 1);
    for (int c = 0; c < 17; c++) cyc(0, 0, 1, 1);

    // back-to-back windows: START on completion edge
    cyc(0, 1, 1, 1);
    for (int c = 0; c < 15; c++) cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 1);
    for (int c = 0; c < 18; c++) cyc(0, 0, 1, 1'($urandom));

    // all-zeros window, long enough for the 256-sample instance
    cyc(0, 1, 1, 0);
    for (int c = 0; c < 260; c++) cyc(0, 0, 1, 0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      s = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 3) != 0);
      cyc(0, s, e, 1'($urandom));
    end

    // mid-run reset
    cyc(0, 1, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(1, 0, 1, 1);
    cyc(0, 0, 1, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sc_stream_counter.md
Name: sc_stream_counter

Overview:
- Stochastic-to-binary converter sitting directly downstream of the 2-input stochastic MUX adder.
- Counts the 1s on a single-bit stochastic stream over a fixed window of 2^WIN_LOG2 enabled cycles, then presents the binary count with a one-cycle valid strobe.
- Used to read back adder/neuron outputs as binary values for the next layer or for the host.

Parameters:
- WIN_LOG2, 8, log2 of window length in counted samples (window WIN = 2^WIN_LOG2; legal range 2..16).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  sample enable; stream bit counted only on cycles with EN=1 (same EN that gates the adder).
- START  in  1  single-cycle request to begin a new window.
- IN  in  1  stochastic bitstream from the upstream adder.
- BUSY  out  1  high while a window is in progress.
- VALID  out  1  one-cycle strobe: RESULT updated this cycle.
- RESULT  out  WIN_LOG2+2  registered result of the last completed window.

Behaviour:
- Reset values (synchronous RST=1 at a clock edge): state IDLE, accumulator 0, sample counter 0, BUSY=0, VALID=0, RESULT=0. RST dominates START/EN in the same cycle.
- States: IDLE, RUN.
  - IDLE -> RUN when START=1; accumulator and sample counter cleared on that edge; BUSY=1 from next cycle.
  - RUN: on each cycle with EN=1, accumulator += IN and sample counter += 1. EN=0 stalls both (no count, no timeout).
  - RUN -> IDLE on the edge where the WIN-th enabled sample is taken. On that same edge RESULT <= final count (including that sample), VALID=1 for exactly one cycle, BUSY=0.
- START in RUN: restarts the window. Accumulator and counter are cleared on that edge; the IN bit of that cycle is not counted; no VALID for the aborted window; RESULT keeps its old value.
- START on the completion edge: completion wins (VALID, RESULT update), and the block enters RUN with cleared counters. BUSY stays 1.
- Latency with EN held 1 and START at cycle t: samples taken at t+1..t+WIN; VALID and new RESULT visible at t+WIN+1.
- Width rules:
  - Accumulator is WIN_LOG2+1 bits unsigned; a max of WIN (all 1s) fits without overflow.
  - Unipolar RESULT = count zero-extended to WIN_LOG2+2 bits.
- RESULT holds between windows; it changes only on a VALID edge or on reset.
- IN and EN are sampled only at clock edges; no combinational paths from inputs to outputs.

Optional Feature:
- Macro: STOCH_BIPOLAR_EN.
- Defined: RESULT = 2*count − WIN, as two's complement in WIN_LOG2+2 bits (range −WIN..+WIN), for bipolar stochastic encoding. Reset value remains 0.
- Undefined: unipolar RESULT as above; no subtractor is synthesised.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=1'b0, RUN=1'b1);
  - a function computing RESULT width from WIN_LOG2;
  - the bipolar-offset helper.
- One natural sub-module: sc_window_timer, an enabled sample counter that asserts a "last" flag on the WIN-th enabled sample and clears on start. The accumulator and FSM stay in the top module.

Test Plan:
- Reset: RST=1 for 3 cycles with START=1 and IN=1 -> BUSY=0, VALID=0, RESULT=0 throughout.
- All-ones window: WIN_LOG2=4, START at t, EN=1, IN=1 -> VALID only at t+17, RESULT=16 (bipolar: +16); BUSY high t+1..t+16.
- 50% stream with stalls: WIN_LOG2=4, IN alternating 1/0, EN low on 5 scattered cycles -> VALID at t+22, RESULT=8 (bipolar: 0).
- All-zeros window in bipolar build: WIN_LOG2=8, IN=0 -> RESULT = −256 (10'b1100000000).
- Restart mid-window: START again at sample 7 of a 16-sample all-ones window -> no VALID at the original completion; VALID 17 cycles after the second START with RESULT=16.
- Back-to-back windows: START asserted on the completion edge -> VALID pulse, BUSY stays 1, second window result valid exactly WIN+1 cycles later.
